// File: rtl/systolic_feeder_if.sv
// Feeder-side bundle: beat handshake toward the feeder, skewed lanes and array strobes away from it.
interface systolic_feeder_if #(
   parameter int WIDTH_A = 16,
   parameter int WIDTH_B = 16,
   parameter int x_axis  = 3,
   parameter int y_axis  = 3,
   parameter int WIDTH_K = 8
);
   logic                        start;
   logic [WIDTH_K-1:0]          k_len;
   logic                        in_valid;
   logic                        in_ready;
   logic [y_axis*WIDTH_A-1:0]   act_vec;
   logic [x_axis*WIDTH_B-1:0]   wei_vec;
   logic [y_axis*WIDTH_A-1:0]   act_skew;
   logic [x_axis*WIDTH_B-1:0]   wei_skew;
   logic                        cell_en;
   logic                        pipeline_en;
   logic                        reg_clear;
   logic                        cscan_en;
   logic                        busy;
   logic                        done;

   modport master (
      output start, k_len, in_valid, act_vec, wei_vec,
      input  in_ready, act_skew, wei_skew, cell_en, pipeline_en, reg_clear, cscan_en, busy, done
   );

   modport slave (
      input  start, k_len, in_valid, act_vec, wei_vec,
      output in_ready, act_skew, wei_skew, cell_en, pipeline_en, reg_clear, cscan_en, busy, done
   );
endinterface

// File: rtl/systolic_feeder.sv
// Diagonal skew + clear/stream/flush/scan sequencer for one output-stationary tile; lane r/c lags r+1/c+1 advances.
// in_valid low in STREAM stalls every lane; define SYSTOLIC_FEEDER_OUT_REG_EN to add one output register stage.
module systolic_feeder #(
   parameter int WIDTH_A = 16,
   parameter int WIDTH_B = 16,
   parameter int x_axis  = 3,
   parameter int y_axis  = 3,
   parameter int WIDTH_K = 8,
   parameter int PE_LAT  = 1
) (
   input  logic           clk,
   input  logic           rst,
   systolic_feeder_if.slave bus
);
   localparam int FLUSH_N = x_axis + y_axis - 2 + PE_LAT;
   localparam int CNT_MAX = (FLUSH_N > x_axis) ? FLUSH_N : x_axis;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] FL_LAST = CW'((FLUSH_N > 0) ? FLUSH_N - 1 : 0);
   localparam logic [CW-1:0] SC_LAST = CW'(x_axis - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, SCAN} state_e;

   state_e             state_q, state_d;
   logic [WIDTH_K-1:0] k_q, k_d;
   logic [WIDTH_K-1:0] beat_q, beat_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               done_q, done_d;
   logic               adv_q, adv;
   logic               start_blk;

   logic                      clr_c, scan_c, en_c, stream_c;
   logic [y_axis*WIDTH_A-1:0] act_c;
   logic [x_axis*WIDTH_B-1:0] wei_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         beat_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         adv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         adv_q   <= adv;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      adv     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start && (bus.k_len != '0) && !start_blk) begin
               state_d = CLEAR;
               k_d     = bus.k_len;
            end
         end
         CLEAR: begin
            state_d = STREAM;
            beat_d  = '0;
            cnt_d   = '0;
         end
         STREAM: begin
            if (bus.in_valid) begin
               adv = 1'b1;
               if (beat_q != k_q) beat_d = beat_q + WIDTH_K'(1);
               if (beat_q + WIDTH_K'(1) == k_q) state_d = (FLUSH_N > 0) ? FLUSH : SCAN;
            end
         end
         FLUSH: begin
            adv = 1'b1;
            if (cnt_q == FL_LAST) begin
               state_d = SCAN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         SCAN: begin
            if (cnt_q == SC_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stream_c = (state_q == STREAM);
   assign clr_c    = (state_q == CLEAR);
   assign scan_c   = (state_q == SCAN);
   // The final flush advance lands in the first SCAN cycle; the array must not accumulate while scanning.
   assign en_c     = adv_q & ~scan_c;

   for (genvar r = 0; r < y_axis; r++) begin : g_act
      logic [WIDTH_A-1:0] sr_q [r+1];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int j = 0; j <= r; j++) sr_q[j] <= '0;
         end else if (adv) begin
            sr_q[0] <= stream_c ? bus.act_vec[r*WIDTH_A +: WIDTH_A] : '0;
            for (int j = 1; j <= r; j++) sr_q[j] <= sr_q[j-1];
         end
      end
      assign act_c[r*WIDTH_A +: WIDTH_A] = sr_q[r];
   end

   for (genvar c = 0; c < x_axis; c++) begin : g_wei
      logic [WIDTH_B-1:0] sr_q [c+1];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int j = 0; j <= c; j++) sr_q[j] <= '0;
         end else if (adv) begin
            sr_q[0] <= stream_c ? bus.wei_vec[c*WIDTH_B +: WIDTH_B] : '0;
            for (int j = 1; j <= c; j++) sr_q[j] <= sr_q[j-1];
         end
      end
      assign wei_c[c*WIDTH_B +: WIDTH_B] = sr_q[c];
   end

`ifdef SYSTOLIC_FEEDER_OUT_REG_EN
   logic [y_axis*WIDTH_A-1:0] act_o_q;
   logic [x_axis*WIDTH_B-1:0] wei_o_q;
   logic                      en_o_q, clr_o_q, scan_o_q, done_o_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         act_o_q  <= '0;
         wei_o_q  <= '0;
         en_o_q   <= 1'b0;
         clr_o_q  <= 1'b0;
         scan_o_q <= 1'b0;
         done_o_q <= 1'b0;
      end else begin
         act_o_q  <= act_c;
         wei_o_q  <= wei_c;
         en_o_q   <= en_c;
         clr_o_q  <= clr_c;
         scan_o_q <= scan_c;
         done_o_q <= done_q;
      end
   end

   // A new tile may only start once the visible done pulse has passed.
   assign start_blk       = done_q | done_o_q;
   assign bus.act_skew    = act_o_q;
   assign bus.wei_skew    = wei_o_q;
   assign bus.cell_en     = en_o_q;
   assign bus.pipeline_en = en_o_q;
   assign bus.reg_clear   = clr_o_q;
   assign bus.cscan_en    = scan_o_q;
   assign bus.done        = done_o_q;
`else
   assign start_blk       = done_q;
   assign bus.act_skew    = act_c;
   assign bus.wei_skew    = wei_c;
   assign bus.cell_en     = en_c;
   assign bus.pipeline_en = en_c;
   assign bus.reg_clear   = clr_c;
   assign bus.cscan_en    = scan_c;
   assign bus.done        = done_q;
`endif

   assign bus.in_ready = stream_c;
   assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes expected lane vectors and strobe cycles, a monitor pops and compares.
module tb_systolic_feeder;
   localparam int WA = 16, WB = 16, X = 3, Y = 3, WK = 8, PL = 1;
   localparam int F  = X + Y - 2 + PL;
   localparam int AW = Y * WA;
   localparam int BW = X * WB;
`ifdef SYSTOLIC_FEEDER_OUT_REG_EN
   localparam int OL = 1;
`else
   localparam int OL = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_feeder_if #(.WIDTH_A(WA), .WIDTH_B(WB), .x_axis(X), .y_axis(Y), .WIDTH_K(WK)) bus ();

   systolic_feeder #(.WIDTH_A(WA), .WIDTH_B(WB), .x_axis(X), .y_axis(Y), .WIDTH_K(WK), .PE_LAT(PL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
      end
   endtask

   // Scoreboard queues
   int                    q_clr[$];
   int                    q_scan[$];
   int                    q_done[$];
   logic [AW+BW-1:0]      q_data[$];
   logic [AW-1:0]         act_beats[$];
   logic [BW-1:0]         wei_beats[$];

   // Lane r at the n-th enabled cycle of a tile shows injected item n-r; items past the beats are zeros.
   function automatic logic [AW+BW-1:0] expect_at(int n);
      logic [AW-1:0] a;
      logic [BW-1:0] w;
      logic [AW-1:0] ta;
      logic [BW-1:0] tw;
      a = '0;
      w = '0;
      for (int r = 0; r < Y; r++) begin
         if (n - r >= 0 && n - r < act_beats.size()) begin
            ta = act_beats[n-r];
            a[r*WA +: WA] = ta[r*WA +: WA];
         end
      end
      for (int c = 0; c < X; c++) begin
         if (n - c >= 0 && n - c < wei_beats.size()) begin
            tw = wei_beats[n-c];
            w[c*WB +: WB] = tw[c*WB +: WB];
         end
      end
      return {a, w};
   endfunction

   // Monitor
   logic             seen_en = 1'b0;
   logic             scan_prev = 1'b0;
   int               scan_start = 0;
   int               scan_len = 0;
   logic [AW+BW-1:0] last_lanes = '0;

   always @(negedge clk) begin
      logic [AW+BW-1:0] e;
      if (rst) begin
         seen_en = 1'b0;
         scan_prev = 1'b0;
         scan_len = 0;
      end else begin
         if (bus.reg_clear) begin
            if (q_clr.size() > 0) chk("clear_cycle", cyc, q_clr.pop_front());
            else chk("unexpected_clear", 1, 0);
            seen_en = 1'b0;
         end
         if (bus.cscan_en) begin
            if (!scan_prev) begin
               scan_start = cyc;
               scan_len = 0;
            end
            scan_len++;
            chk("pipe_en_in_scan", bus.pipeline_en, 0);
            chk("cell_en_in_scan", bus.cell_en, 0);
         end else if (scan_prev) begin
            if (q_scan.size() > 0) chk("scan_start", scan_start, q_scan.pop_front());
            else chk("unexpected_scan", 1, 0);
            chk("scan_len", scan_len, X);
         end
         scan_prev = bus.cscan_en;
         if (bus.done) begin
            if (q_done.size() > 0) chk("done_cycle", cyc, q_done.pop_front());
            else chk("unexpected_done", 1, 0);
         end
         if (bus.pipeline_en) begin
            chk("cell_en_with_data", bus.cell_en, 1);
            if (q_data.size() > 0) begin
               e = q_data.pop_front();
               chk("act_lanes", bus.act_skew, e[AW+BW-1:BW]);
               chk("wei_lanes", bus.wei_skew, e[BW-1:0]);
            end else begin
               chk("unexpected_advance", 1, 0);
            end
            last_lanes = {bus.act_skew, bus.wei_skew};
            seen_en = 1'b1;
         end else if (bus.in_ready && seen_en) begin
            chk("stall_hold", {bus.act_skew, bus.wei_skew}, last_lanes);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_act"}, bus.act_skew, 0);
      chk({tag, "_wei"}, bus.wei_skew, 0);
      chk({tag, "_strobes"}, {bus.cell_en, bus.pipeline_en, bus.reg_clear, bus.cscan_en}, 0);
      chk({tag, "_busy_done_rdy"}, {bus.busy, bus.done, bus.in_ready}, 0);
   endtask

   // mode 0: directed values, no stalls; mode 1: two-cycle stall after beat 1; mode 2: random values and stalls
   task automatic run_tile(input int k, input int mode);
      int s, b, l, stalls, d;
      logic v;
      logic [63:0] t;
      act_beats.delete();
      wei_beats.delete();
      s = cyc;
      bus.start = 1'b1;
      bus.k_len = WK'(k);
      q_clr.push_back(s + 1 + OL);
      tick();
      bus.start = 1'b0;
      chk("in_ready_clear", bus.in_ready, 0);
      chk("busy_clear", bus.busy, 1);
      tick();
      chk("in_ready_stream", bus.in_ready, 1);
      b = 0;
      stalls = 0;
      while (b < k) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = !(b == 1 && stalls < 2);
            default: v = ($urandom_range(0, 3) != 0) || stalls > 20;
         endcase
         if (mode == 0) begin
            for (int r = 0; r < Y; r++) bus.act_vec[r*WA +: WA] = WA'(3 * b + r + 1);
            for (int c = 0; c < X; c++) bus.wei_vec[c*WB +: WB] = WB'(10 * (b + 1) + c);
         end else begin
            t = {$urandom(), $urandom()};
            bus.act_vec = t[AW-1:0];
            t = {$urandom(), $urandom()};
            bus.wei_vec = t[BW-1:0];
         end
         bus.in_valid = v;
         if (v) begin
            act_beats.push_back(bus.act_vec);
            wei_beats.push_back(bus.wei_vec);
            q_data.push_back(expect_at(b));
            b++;
         end else begin
            stalls++;
         end
         tick();
      end
      l = cyc - 1;
      bus.in_valid = 1'b0;
      for (int n = k; n < k + F - 1; n++) q_data.push_back(expect_at(n));
      d = l + F + X + 1 + OL;
      q_scan.push_back(l + F + 1 + OL);
      q_done.push_back(d);
      tick();
      // A start and junk beat inside FLUSH must not disturb the tile.
      bus.start = 1'b1;
      bus.k_len = WK'(5);
      bus.in_valid = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      while (cyc < d) tick();
      chk("busy_in_done_cycle", bus.busy, 0);
      bus.start = 1'b1;
      bus.k_len = WK'(3);
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.k_len = '0;
      bus.in_valid = 1'b0;
      bus.act_vec = '0;
      bus.wei_vec = '0;
      tick();
      check_all_zero("reset_hold");
      tick();
      rst = 1'b0;
      tick();
      check_all_zero("after_reset");

      // start with zero length is ignored
      bus.start = 1'b1;
      bus.k_len = '0;
      tick();
      bus.start = 1'b0;
      chk("k0_busy", bus.busy, 0);
      tick();
      chk("k0_busy_later", bus.busy, 0);
      tick();

      run_tile(3, 0);
      run_tile(2, 1);
      run_tile(4, 0);

      // reset in the middle of STREAM
      tick();
      bus.start = 1'b1;
      bus.k_len = WK'(3);
      q_clr.push_back(cyc + 1 + OL);
      tick();
      bus.start = 1'b0;
      tick();
      bus.in_valid = 1'b1;
      bus.act_vec = AW'(48'h0003_0002_0001);
      bus.wei_vec = BW'(48'h0012_0011_0010);
      tick();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check_all_zero("mid_reset");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 25; i++) tick();
      chk("post_reset_busy", bus.busy, 0);

      for (int i = 0; i < 6; i++) run_tile($urandom_range(1, 8), 2);

      for (int i = 0; i < 10; i++) tick();
      chk("pending_clear", q_clr.size(), 0);
      chk("pending_scan", q_scan.size(), 0);
      chk("pending_done", q_done.size(), 0);
      chk("pending_data", q_data.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
